// File: rtl/sobel_stream_out_if.sv
// Pixel stream bundle between sobel_stream_out and its downstream consumer.
// Carries valid/ready handshake, pixel data, position and framing markers.
interface sobel_stream_out_if #(
  parameter int PIX_W = 11,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
);
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic [ROW_W-1:0] m_row;
  logic [COL_W-1:0] m_col;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (
    output m_valid, m_data, m_row, m_col, m_sof, m_eol, m_eof,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_row, m_col, m_sof, m_eol, m_eof,
    output m_ready
  );
endinterface

// File: rtl/sobel_stream_out.sv
// Captures a full Sobel result frame on start and streams it out row-major.
// Optional macro SOBEL_SAT_EN clamps streamed pixels to 255.
module sobel_stream_out #(
  parameter int ROWS  = 6,
  parameter int COLS  = 7,
  parameter int PIX_W = 11
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [ROWS-1:0][COLS-1:0][PIX_W-1:0]  frame_in,
  output logic                                  busy,
  output logic                                  done,
  sobel_stream_out_if.master                    m
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                                state;
  logic [ROW_W-1:0]                      row_p0;
  logic [COL_W-1:0]                      col_p0;
  logic                                  vld_p0;
  logic [ROWS-1:0][COLS-1:0][PIX_W-1:0]  frame_p0;

  function automatic logic [PIX_W-1:0] pix_out(input logic [PIX_W-1:0] v);
`ifdef SOBEL_SAT_EN
    return (v > PIX_W'(255)) ? PIX_W'(255) : v;
`else
    return v;
`endif
  endfunction

  // Stage p0: control FSM, position counters and handshake state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      row_p0 <= '0;
      col_p0 <= '0;
      vld_p0 <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= STREAM;
            row_p0 <= '0;
            col_p0 <= '0;
            vld_p0 <= 1'b1;
            busy   <= 1'b1;
          end
        end
        STREAM: begin
          if (m.m_ready) begin
            if (col_p0 == COL_LAST) begin
              col_p0 <= '0;
              if (row_p0 == ROW_LAST) begin
                // counters wrap to 0 so idle outputs read as zero positions
                row_p0 <= '0;
                state  <= IDLE;
                vld_p0 <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                row_p0 <= row_p0 + 1'b1;
              end
            end else begin
              col_p0 <= col_p0 + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame buffer is data only: loaded on an idle start and otherwise held
  always_ff @(posedge clk) begin
    if (state == IDLE && start) frame_p0 <= frame_in;
  end

  // Output: buffer contents are gated so reset and idle show zero data
  assign m.m_valid = vld_p0;
  assign m.m_data  = vld_p0 ? pix_out(frame_p0[row_p0][col_p0]) : '0;
  assign m.m_row   = row_p0;
  assign m.m_col   = col_p0;
  assign m.m_sof   = vld_p0 && (row_p0 == '0) && (col_p0 == '0);
  assign m.m_eol   = vld_p0 && (col_p0 == COL_LAST);
  assign m.m_eof   = vld_p0 && (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);
endmodule
